// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bundle of all non-clock/reset ports of regfile_mp.
//   master : decode/writeback side (drives addresses, write ports, scoreboard set)
//   slave  : the register file (drives read data, busy, ready, err_conflict)
// Read ports are packed flat: port i = rd_addr[i*AW +: AW], rd_data[i*XLEN +: XLEN].
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic                 ready;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 wa_en;
  logic [AW-1:0]        wa_addr;
  logic [XLEN-1:0]      wa_data;
  logic                 wb_en;
  logic [AW-1:0]        wb_addr;
  logic [XLEN-1:0]      wb_data;
  logic                 sb_set;
  logic [AW-1:0]        sb_addr;
  logic [AW-1:0]        dbg_addr;
  logic [XLEN-1:0]      dbg_data;
  logic                 err_conflict;

  modport master (
    input  ready, rd_data, rd_busy, dbg_data, err_conflict,
    output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           sb_set, sb_addr, dbg_addr
  );

  modport slave (
    output ready, rd_data, rd_busy, dbg_data, err_conflict,
    input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           sb_set, sb_addr, dbg_addr
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with busy scoreboard.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : regfile_mp_if.slave
//     NRD combinational read ports (data + busy), write port A (ALU/load),
//     write port B (MUL/DIV), scoreboard set, debug read, ready, err_conflict.
// After reset a sequencer zeroes entries 1..NREGS-1 (x0 is hardwired to 0 on
// reads and never stored) before ready rises; all operations are ignored and
// all read outputs read 0 until then.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_mp_if.slave bus
);
  localparam int AW  = $clog2(NREGS);
  localparam bit BYP = (BYPASS != 0);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   mem_q [NREGS];
  logic [XLEN-1:0]   mem_d [NREGS];

  logic run, wa_ok, wb_ok;
  assign run   = (state_q == RUN);
  // Qualified writes: only in RUN and never to x0.
  assign wa_ok = run && bus.wa_en && (bus.wa_addr != '0);
  assign wb_ok = run && bus.wb_en && (bus.wb_addr != '0);

  // Clear sequencer: counter starts at 1 (x0 needs no storage), leaves CLEAR
  // on the edge that writes the last entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AW'(NREGS-1)) state_d = RUN;
    end
  end

  // Storage update. Port A is applied last so it wins a same-address collision
  // (it carries the younger instruction).
  always_comb begin
    for (int i = 0; i < NREGS; i++) mem_d[i] = mem_q[i];
    if (state_q == CLEAR) mem_d[cnt_q] = '0;
    if (wb_ok) mem_d[bus.wb_addr] = bus.wb_data;
    if (wa_ok) mem_d[bus.wa_addr] = bus.wa_data;
  end

  // Scoreboard: set applied after clear so a same-cycle set on the register
  // being written back keeps it busy (a new long op was issued to it).
  always_comb begin
    busy_d = busy_q;
    if (wb_ok) busy_d[bus.wb_addr] = 1'b0;
    if (run && bus.sb_set && (bus.sb_addr != '0)) busy_d[bus.sb_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign err_d = wa_ok && wb_ok && (bus.wa_addr == bus.wb_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= AW'(1);
      busy_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Array has no reset; the clear sequencer initialises it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) mem_q[i] <= mem_d[i];
  end

  // Read ports. Bypass order mirrors write priority: port A over port B.
  // A port-B writeback bypassed into a read also hides the busy bit it clears.
  logic [NRD-1:0][AW-1:0]   ra;
  logic [NRD-1:0][XLEN-1:0] rd_data_w;
  logic [NRD-1:0]           rd_busy_w;

  assign ra = bus.rd_addr;

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_data_w[i] = '0;
      rd_busy_w[i] = 1'b0;
      if (run && (ra[i] != '0)) begin
        rd_data_w[i] = mem_q[ra[i]];
        rd_busy_w[i] = busy_q[ra[i]];
        if (BYP && bus.wb_en && (bus.wb_addr == ra[i])) begin
          rd_data_w[i] = bus.wb_data;
          rd_busy_w[i] = 1'b0;
        end
        if (BYP && bus.wa_en && (bus.wa_addr == ra[i])) rd_data_w[i] = bus.wa_data;
      end
    end
  end

  assign bus.rd_data      = rd_data_w;
  assign bus.rd_busy      = rd_busy_w;
  assign bus.dbg_data     = (run && (bus.dbg_addr != '0)) ? mem_q[bus.dbg_addr] : '0;
  assign bus.ready        = run;
  assign bus.err_conflict = err_q;
endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // a: default build (BYPASS=1); n: BYPASS=0 copy fed the same inputs;
  // w: NRD=3, NREGS=16, XLEN=64 build.
  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) a();
  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) n();
  regfile_mp_if #(.XLEN(64), .NREGS(16), .NRD(3)) w();

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) u_n (.clk(clk), .rst_n(rst_n), .bus(n.slave));
  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3), .BYPASS(1)) u_w (.clk(clk), .rst_n(rst_n), .bus(w.slave));

  assign n.rd_addr  = a.rd_addr;
  assign n.wa_en    = a.wa_en;
  assign n.wa_addr  = a.wa_addr;
  assign n.wa_data  = a.wa_data;
  assign n.wb_en    = a.wb_en;
  assign n.wb_addr  = a.wb_addr;
  assign n.wb_data  = a.wb_data;
  assign n.sb_set   = a.sb_set;
  assign n.sb_addr  = a.sb_addr;
  assign n.dbg_addr = a.dbg_addr;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    a.wa_en = 1'b0; a.wb_en = 1'b0; a.sb_set = 1'b0;
    w.wa_en = 1'b0; w.wb_en = 1'b0; w.sb_set = 1'b0;
  endtask

  // Counts edges from reset release until ready, for both builds.
  task automatic count_clear(string tag);
    int ea = -1;
    int ew = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (a.ready && ea < 0) begin ea = e; idle(); end
      if (w.ready && ew < 0) ew = e;
    end
    n_chk++; if (ea !== 31) begin n_fail++; $display("FAIL %s_ready_edge_a got=%0d exp=31", tag, ea); end
    n_chk++; if (ew !== 15) begin n_fail++; $display("FAIL %s_ready_edge_w got=%0d exp=15", tag, ew); end
  endtask

  task automatic sweep_zero(string tag);
    for (int i = 0; i < 32; i++) begin
      a.dbg_addr = 5'(i); #1;
      n_chk++; if (a.dbg_data !== 32'h0) begin n_fail++; $display("FAIL %s_dbg_a[%0d] got=%h exp=0", tag, i, a.dbg_data); end
    end
    for (int i = 0; i < 16; i++) begin
      w.dbg_addr = 4'(i); #1;
      n_chk++; if (w.dbg_data !== 64'h0) begin n_fail++; $display("FAIL %s_dbg_w[%0d] got=%h exp=0", tag, i, w.dbg_data); end
    end
  endtask

  task automatic test_reset();
    a.rd_addr = '0; a.wa_addr = '0; a.wa_data = '0; a.wb_addr = '0; a.wb_data = '0;
    a.sb_addr = '0; a.dbg_addr = '0;
    w.rd_addr = '0; w.wa_addr = '0; w.wa_data = '0; w.wb_addr = '0; w.wb_data = '0;
    w.sb_addr = '0; w.dbg_addr = '0;
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_chk++; if (a.ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", a.ready); end
    n_chk++; if (a.err_conflict !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", a.err_conflict); end
    n_chk++; if (w.ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_w got=%b exp=0", w.ready); end
    rst_n = 1'b1;
    // Writes/sets during CLEAR must be ignored.
    a.wa_en = 1'b1; a.wa_addr = 5'd5; a.wa_data = 32'h5555_5555;
    a.sb_set = 1'b1; a.sb_addr = 5'd6;
    a.rd_addr = {5'd6, 5'd5}; a.dbg_addr = 5'd5;
    @(negedge clk);
    n_chk++; if (a.rd_data !== 64'h0) begin n_fail++; $display("FAIL clear_rd got=%h exp=0", a.rd_data); end
    n_chk++; if (a.dbg_data !== 32'h0) begin n_fail++; $display("FAIL clear_dbg got=%h exp=0", a.dbg_data); end
    count_clear("init");
    sweep_zero("init");
    a.rd_addr = {5'd5, 5'd6}; #1;
    n_chk++; if (a.rd_busy !== 2'b00) begin n_fail++; $display("FAIL clear_sbset_ignored got=%b exp=00", a.rd_busy); end
    n_chk++; if (a.rd_data[63:32] !== 32'h0) begin n_fail++; $display("FAIL clear_x5 got=%h exp=0", a.rd_data[63:32]); end
  endtask

  task automatic test_bypass();
    tick();
    a.wa_en = 1'b1; a.wa_addr = 5'd3; a.wa_data = 32'h0000_DEAD;
    a.rd_addr = {5'd0, 5'd3}; a.dbg_addr = 5'd3;
    @(negedge clk);
    n_chk++; if (a.rd_data[31:0] !== 32'h0000_DEAD) begin n_fail++; $display("FAIL byp_same_a got=%h exp=0000dead", a.rd_data[31:0]); end
    n_chk++; if (n.rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL byp_same_n got=%h exp=0", n.rd_data[31:0]); end
    n_chk++; if (a.rd_data[63:32] !== 32'h0) begin n_fail++; $display("FAIL byp_x0 got=%h exp=0", a.rd_data[63:32]); end
    n_chk++; if (a.dbg_data !== 32'h0) begin n_fail++; $display("FAIL byp_dbg_nobyp got=%h exp=0", a.dbg_data); end
    tick(); idle();
    @(negedge clk);
    n_chk++; if (a.rd_data[31:0] !== 32'h0000_DEAD) begin n_fail++; $display("FAIL byp_next_a got=%h exp=0000dead", a.rd_data[31:0]); end
    n_chk++; if (n.rd_data[31:0] !== 32'h0000_DEAD) begin n_fail++; $display("FAIL byp_next_n got=%h exp=0000dead", n.rd_data[31:0]); end
    n_chk++; if (a.dbg_data !== 32'h0000_DEAD) begin n_fail++; $display("FAIL byp_dbg_next got=%h exp=0000dead", a.dbg_data); end
    // Port B bypass on read port 1.
    tick();
    a.wb_en = 1'b1; a.wb_addr = 5'd4; a.wb_data = 32'h0000_0044; a.rd_addr = {5'd4, 5'd3};
    @(negedge clk);
    n_chk++; if (a.rd_data[63:32] !== 32'h0000_0044) begin n_fail++; $display("FAIL bypb_a got=%h exp=00000044", a.rd_data[63:32]); end
    n_chk++; if (n.rd_data[63:32] !== 32'h0) begin n_fail++; $display("FAIL bypb_n got=%h exp=0", n.rd_data[63:32]); end
    tick(); idle();
  endtask

  task automatic test_conflict();
    tick();
    a.wa_en = 1'b1; a.wa_addr = 5'd7; a.wa_data = 32'h1111_1111;
    a.wb_en = 1'b1; a.wb_addr = 5'd7; a.wb_data = 32'h2222_2222;
    a.rd_addr = {5'd0, 5'd7};
    @(negedge clk);
    n_chk++; if (a.rd_data[31:0] !== 32'h1111_1111) begin n_fail++; $display("FAIL conf_byp_prio got=%h exp=11111111", a.rd_data[31:0]); end
    n_chk++; if (a.err_conflict !== 1'b0) begin n_fail++; $display("FAIL conf_err_early got=%b exp=0", a.err_conflict); end
    tick(); idle();
    @(negedge clk);
    n_chk++; if (a.err_conflict !== 1'b1) begin n_fail++; $display("FAIL conf_err got=%b exp=1", a.err_conflict); end
    n_chk++; if (a.rd_data[31:0] !== 32'h1111_1111) begin n_fail++; $display("FAIL conf_store_a got=%h exp=11111111", a.rd_data[31:0]); end
    n_chk++; if (n.rd_data[31:0] !== 32'h1111_1111) begin n_fail++; $display("FAIL conf_store_n got=%h exp=11111111", n.rd_data[31:0]); end
    tick();
    @(negedge clk);
    n_chk++; if (a.err_conflict !== 1'b0) begin n_fail++; $display("FAIL conf_err_width got=%b exp=0", a.err_conflict); end
    // Both ports to x0: no error, x0 stays 0.
    tick();
    a.wa_en = 1'b1; a.wa_addr = 5'd0; a.wa_data = 32'hDEAD_BEEF;
    a.wb_en = 1'b1; a.wb_addr = 5'd0; a.wb_data = 32'hCAFE_F00D;
    a.rd_addr = {5'd7, 5'd0}; a.dbg_addr = 5'd0;
    @(negedge clk);
    n_chk++; if (a.rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL x0_byp got=%h exp=0", a.rd_data[31:0]); end
    tick(); idle();
    @(negedge clk);
    n_chk++; if (a.err_conflict !== 1'b0) begin n_fail++; $display("FAIL x0_err got=%b exp=0", a.err_conflict); end
    n_chk++; if (a.dbg_data !== 32'h0) begin n_fail++; $display("FAIL x0_dbg got=%h exp=0", a.dbg_data); end
    // Different addresses: both stored, no error.
    tick();
    a.wa_en = 1'b1; a.wa_addr = 5'd10; a.wa_data = 32'h0000_000A;
    a.wb_en = 1'b1; a.wb_addr = 5'd11; a.wb_data = 32'h0000_000B;
    tick(); idle(); a.rd_addr = {5'd11, 5'd10};
    @(negedge clk);
    n_chk++; if (a.err_conflict !== 1'b0) begin n_fail++; $display("FAIL diff_err got=%b exp=0", a.err_conflict); end
    n_chk++; if (a.rd_data !== {32'h0000_000B, 32'h0000_000A}) begin n_fail++; $display("FAIL diff_store got=%h exp=0000000b0000000a", a.rd_data); end
  endtask

  task automatic test_scoreboard();
    tick();
    a.sb_set = 1'b1; a.sb_addr = 5'd9; a.rd_addr = {5'd0, 5'd9};
    @(negedge clk);
    n_chk++; if (a.rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL sb_same_cycle got=%b exp=0", a.rd_busy[0]); end
    tick(); idle();
    repeat (3) tick();
    @(negedge clk);
    n_chk++; if (a.rd_busy !== 2'b01) begin n_fail++; $display("FAIL sb_busy_a got=%b exp=01", a.rd_busy); end
    n_chk++; if (n.rd_busy !== 2'b01) begin n_fail++; $display("FAIL sb_busy_n got=%b exp=01", n.rd_busy); end
    tick();
    a.wb_en = 1'b1; a.wb_addr = 5'd9; a.wb_data = 32'h0000_0064;
    @(negedge clk);
    n_chk++; if (a.rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL sb_wb_busy_a got=%b exp=0", a.rd_busy[0]); end
    n_chk++; if (a.rd_data[31:0] !== 32'h0000_0064) begin n_fail++; $display("FAIL sb_wb_data_a got=%h exp=00000064", a.rd_data[31:0]); end
    n_chk++; if (n.rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL sb_wb_busy_n got=%b exp=1", n.rd_busy[0]); end
    n_chk++; if (n.rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL sb_wb_data_n got=%h exp=0", n.rd_data[31:0]); end
    tick(); idle();
    @(negedge clk);
    n_chk++; if (a.rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL sb_cleared_a got=%b exp=0", a.rd_busy[0]); end
    n_chk++; if (n.rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL sb_cleared_n got=%b exp=0", n.rd_busy[0]); end
    // Set x9 again, then set and writeback in the same cycle: set wins.
    tick(); a.sb_set = 1'b1; a.sb_addr = 5'd9;
    tick();
    a.wb_en = 1'b1; a.wb_addr = 5'd9; a.wb_data = 32'h0000_0065;
    tick(); idle();
    @(negedge clk);
    n_chk++; if (a.rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL sb_set_wins got=%b exp=1", a.rd_busy[0]); end
    n_chk++; if (a.rd_data[31:0] !== 32'h0000_0065) begin n_fail++; $display("FAIL sb_set_wins_data got=%h exp=00000065", a.rd_data[31:0]); end
    // sb_set on x0 never marks it busy.
    tick(); a.sb_set = 1'b1; a.sb_addr = 5'd0;
    tick(); idle(); a.rd_addr = {5'd9, 5'd0};
    @(negedge clk);
    n_chk++; if (a.rd_busy !== 2'b10) begin n_fail++; $display("FAIL sb_x0 got=%b exp=10", a.rd_busy); end
  endtask

  task automatic test_wide();
    tick();
    w.wa_en = 1'b1; w.wa_addr = 4'd1; w.wa_data = 64'h0123_4567_89AB_CDEF;
    w.wb_en = 1'b1; w.wb_addr = 4'd15; w.wb_data = 64'hFEDC_BA98_7654_3210;
    w.rd_addr = {4'd0, 4'd1, 4'd15};
    @(negedge clk);
    n_chk++; if (w.rd_data !== {64'h0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210}) begin n_fail++; $display("FAIL wide_byp got=%h", w.rd_data); end
    tick();
    w.wb_en = 1'b0; w.wa_addr = 4'd2; w.wa_data = 64'hAAAA_0000_5555_FFFF;
    w.rd_addr = {4'd15, 4'd2, 4'd1};
    @(negedge clk);
    n_chk++; if (w.rd_data !== {64'hFEDC_BA98_7654_3210, 64'hAAAA_0000_5555_FFFF, 64'h0123_4567_89AB_CDEF}) begin n_fail++; $display("FAIL wide_mix got=%h", w.rd_data); end
    tick(); idle();
    w.rd_addr = {4'd2, 4'd15, 4'd3};
    @(negedge clk);
    n_chk++; if (w.rd_data !== {64'hAAAA_0000_5555_FFFF, 64'hFEDC_BA98_7654_3210, 64'h0}) begin n_fail++; $display("FAIL wide_stored got=%h", w.rd_data); end
  endtask

  task automatic test_midreset();
    // x9 is busy and x3/x7/x9 hold data from earlier tests.
    a.rd_addr = {5'd3, 5'd9};
    tick();
    rst_n = 1'b0; #1;
    n_chk++; if (a.ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready got=%b exp=0", a.ready); end
    n_chk++; if (a.rd_busy !== 2'b00) begin n_fail++; $display("FAIL mid_busy got=%b exp=00", a.rd_busy); end
    n_chk++; if (a.rd_data !== 64'h0) begin n_fail++; $display("FAIL mid_rd got=%h exp=0", a.rd_data); end
    n_chk++; if (w.ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_w got=%b exp=0", w.ready); end
    tick();
    rst_n = 1'b1;
    count_clear("mid");
    sweep_zero("mid");
    a.rd_addr = {5'd3, 5'd9}; #1;
    n_chk++; if (a.rd_busy !== 2'b00) begin n_fail++; $display("FAIL mid_busy_after got=%b exp=00", a.rd_busy); end
    n_chk++; if (a.rd_data !== 64'h0) begin n_fail++; $display("FAIL mid_rd_after got=%h exp=0", a.rd_data); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_conflict();
    test_scoreboard();
    test_wide();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RV32IM core, succeeding the fixed 2-read/1-write file. It provides NRD combinational read ports, two write ports (port A: single-cycle ALU/load writeback; port B: long-latency MUL/DIV writeback), optional same-cycle write-to-read bypass, and a per-register busy scoreboard for outstanding MUL/DIV results. After reset, a hardware clear sequencer zeroes the file, replacing simulation-only initial values. It sits between decode (reads, scoreboard set) and writeback.

## Interface
- XLEN, 32, data width
- NREGS, 32, register count; power of 2, ≥4; AW = clog2(NREGS) derived internally
- NRD, 2, number of read ports
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = new value visible the next cycle

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ready  out  1  file cleared and accepting operations
- rd_addr  in  NRD*AW  read addresses; port i = bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data, same packing
- rd_busy  out  NRD  scoreboard busy bit per read port
- wa_en, wa_addr[AW], wa_data[XLEN]  in  write port A
- wb_en, wb_addr[AW], wb_data[XLEN]  in  write port B
- sb_set  in  1  mark sb_addr pending (long-latency op issued)
- sb_addr  in  AW  register to mark
- dbg_addr  in  AW  debug read address
- dbg_data  out  XLEN  debug read data (stored value, never bypassed)
- err_conflict  out  1  registered one-cycle pulse: both write ports hit the same nonzero address

## Operation
- States: CLEAR, RUN.
- rst_n low (async): state=CLEAR, clear counter=1, all busy bits=0, ready=0, err_conflict=0. Array contents are not reset asynchronously.
- CLEAR: on each rising edge, write 0 to entry[counter] and increment; at the edge where counter==NREGS-1 (written), go to RUN. In CLEAR, wa_en/wb_en/sb_set are ignored; rd_data, rd_busy and dbg_data read 0.
- RUN writes: on the rising edge, wa_en writes wa_data to wa_addr; wb_en writes wb_data to wb_addr. Same nonzero address on both: port A's value is stored (younger instruction) and err_conflict=1 in the next cycle only.
- x0: writes to address 0 are discarded; reads of 0 return 0; busy[0] is never set.
- Read mux per port: addr 0 → 0; else if BYPASS and wa_en and wa_addr==addr → wa_data; else if BYPASS and wb_en and wb_addr==addr → wb_data; else stored value.
- Scoreboard: sb_set sets busy[sb_addr] on the edge; wb_en clears busy[wb_addr] on the edge. If set and clear hit the same register in one cycle, set wins. A wb_en write to a non-busy register is still performed.
- rd_busy[i] = busy[addr_i] & ~(BYPASS & wb_en & wb_addr==addr_i); forced 0 for address 0. sb_set never affects same-cycle rd_busy.
- rst_n asserted mid-operation: ready drops immediately, busy bits clear, and the full CLEAR sequence reruns after deassertion.

## Timing
- Reads, rd_busy, dbg_data: combinational from addresses and state.
- Writes: stored at the rising edge; visible via non-bypass path in the following cycle.
- ready rises after the (NREGS-1)th rising edge following rst_n deassertion (31 edges by default); it is combinationally usable in that cycle.
- err_conflict: one cycle after the conflicting edge, one cycle wide.
- No stalls or backpressure; every enabled RUN-state write completes in one edge.

## Test plan
- Reset, release, count edges -> ready=0 for 30 edges and 1 after the 31st; all 32 entries read 0 via dbg; wa_en to x5 during CLEAR is not stored.
- RUN: wa writes x3=0x0000DEAD, same-cycle read of x3 -> 0x0000DEAD (BYPASS=1) or old value 0 (BYPASS=0); next cycle -> 0x0000DEAD in both builds.
- wa_en and wb_en to x7 (0x11111111 / 0x22222222) in one cycle -> x7=0x11111111, err_conflict high exactly one cycle later; both to x0 -> no error, x0 reads 0.
- sb_set x9, then 3 idle cycles -> rd_busy=1; wb_en x9=0x00000064 -> same-cycle rd_busy=0 and rd_data=0x64 (BYPASS=1); busy clear afterwards. Same-cycle sb_set x9 + wb_en x9 -> busy stays 1.
- Assert rst_n mid-RUN with x9 busy and data written -> ready=0 immediately, rd_busy=0, and after 31 edges all entries read 0.
- NRD=3, NREGS=16, XLEN=64 build -> three independent read ports correct; ready after 15 edges.
